// File: rtl/tff_share_arbiter.sv
// tff_share_arbiter: round-robin share of one predicate-driven T flip-flop among NREQ requesters
//   Clk        rising-edge clock
//   Rst        synchronous active-high reset
//   req        per-requester level request, held until its done
//   in_data    requester i word on in_data[4i+3:4i]
//   gnt        registered one-hot grant
//   done       one-cycle one-hot completion pulse
//   busy       high while an operation is in flight
//   Q          shared toggle state
//   z_last     predicate of the last completed operation
//   toggle_cnt number of operations with Z=1, wrapping
module tff_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] in_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              Q,
    output logic              z_last,
    output logic [CNT_W-1:0]  toggle_cnt
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, APPLY, RESP} state_t;
    state_t        state, state_n;
    logic [IW-1:0] ptr, widx, win;
    logic [3:0]    wreg;
    logic          found, z;
    int            j;
    assign z    = (wreg[0] & wreg[1]) | wreg[2] | wreg[3];
    assign busy = state != IDLE;
    // search upward from ptr, wrapping, so the first requester at or after ptr wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            j = (j >= NREQ) ? j - NREQ : j;
            if (!found && req[IW'(j)]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
        state_n = (state == IDLE)  ? (found ? APPLY : IDLE) :
                  (state == APPLY) ? RESP : IDLE;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            gnt        <= '0;
            done       <= '0;
            Q          <= 1'b0;
            z_last     <= 1'b0;
            toggle_cnt <= '0;
            ptr        <= '0;
            widx       <= '0;
            wreg       <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && found) begin
                wreg <= in_data[4*win +: 4];
                widx <= win;
                gnt  <= NREQ'(1) << win;
            end
            if (state == APPLY) begin
                Q          <= Q ^ z;
                z_last     <= z;
                toggle_cnt <= toggle_cnt + CNT_W'(z);
                done       <= NREQ'(1) << widx;
            end
            if (state == RESP) begin
                done <= '0;
                gnt  <= '0;
                ptr  <= (widx == IW'(NREQ - 1)) ? '0 : widx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tff_share_arbiter.sv
// tb_tff_share_arbiter: directed and random checks of tff_share_arbiter against a transaction-level model
module tb_tff_share_arbiter;
    localparam int NREQ  = 4;
    localparam int CNT_W = 8;
    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [4*NREQ-1:0] in_data = '0;
    logic [NREQ-1:0]   gnt, done;
    logic              busy, Q, z_last;
    logic [CNT_W-1:0]  toggle_cnt;
    int n_cmp = 0;
    int n_err = 0;
    // model: age = -1 when idle, else edges elapsed since the grant
    int m_age = -1, m_ptr = 0, m_idx = 0, m_word = 0, m_q = 0, m_z = 0, m_cnt = 0;
    tff_share_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .req(req), .in_data(in_data), .gnt(gnt), .done(done),
        .busy(busy), .Q(Q), .z_last(z_last), .toggle_cnt(toggle_cnt)
    );
    always #5 Clk = ~Clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic model_edge();
        int zz;
        if (Rst) begin
            m_age = -1; m_ptr = 0; m_q = 0; m_z = 0; m_cnt = 0;
        end else if (m_age < 0) begin
            for (int k = NREQ - 1; k >= 0; k--)
                if (req[(m_ptr + k) % NREQ]) m_idx = (m_ptr + k) % NREQ;
            if (req != 0) begin
                m_word = int'(in_data >> (4 * m_idx)) & 15;
                m_age  = 0;
            end
        end else if (m_age == 0) begin
            zz    = ((m_word & 3) == 3 || (m_word & 12) != 0) ? 1 : 0;
            m_q   = m_q ^ zz;
            m_z   = zz;
            m_cnt = (m_cnt + zz) % (1 << CNT_W);
            m_age = 1;
        end else begin
            m_ptr = (m_idx + 1) % NREQ;
            m_age = -1;
        end
    endtask
    task automatic step();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check("gnt", gnt, (m_age >= 0) ? (1 << m_idx) : 0);
        check("done", done, (m_age == 1) ? (1 << m_idx) : 0);
        check("busy", busy, (m_age >= 0) ? 1 : 0);
        check("Q", Q, m_q);
        check("z_last", z_last, m_z);
        check("toggle_cnt", toggle_cnt, m_cnt);
    endtask
    initial begin
        Rst = 1'b1; req = 4'b1111; in_data = 16'hFFFF;
        step(); step();
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        Rst = 1'b0; req = 4'b0001; in_data = 16'h0003;
        step(); check("single_gnt", gnt, 4'b0001);
        step(); check("single_done", done, 4'b0001);
        check("single_q", Q, 1); check("single_cnt", toggle_cnt, 1);
        step(); in_data = 16'h0001;
        step(); step();
        check("single2_q", Q, 1); check("single2_z", z_last, 0); check("single2_cnt", toggle_cnt, 1);
        req = '0; step();
        Rst = 1'b1; step(); Rst = 1'b0;
        req = 4'b1111; in_data = 16'hCCCC;
        for (int n = 0; n < 15; n++) begin
            step();
            if (n % 3 == 0) check("rr_gnt", gnt, 1 << ((n / 3) % 4));
        end
        check("rr_cnt", toggle_cnt, 5); check("rr_q", Q, 1);
        req = '0; step();
        Rst = 1'b1; step(); Rst = 1'b0;
        req = 4'b0100; in_data = 16'h0400;
        step(); check("wrap_g2", gnt, 4'b0100);
        req = '0; step(); step();
        req = 4'b0101;
        step(); check("wrap_g0", gnt, 4'b0001);
        step(); step();
        step(); check("wrap_g2b", gnt, 4'b0100);
        req = '0; step(); step();
        in_data = 16'h00F0; req = 4'b0010;
        step(); check("fly_gnt", gnt, 4'b0010);
        in_data = 16'h0000; req = '0;
        step(); check("fly_done", done, 4'b0010); check("fly_z", z_last, 1);
        step();
        Rst = 1'b1; step(); Rst = 1'b0;
        req = 4'b0001; in_data = 16'h000F;
        step();
        Rst = 1'b1; step();
        check("rst_mid_done", done, 0); check("rst_mid_q", Q, 0);
        Rst = 1'b0; req = '0;
        step(); check("rst_mid_busy", busy, 0);
        req = 4'b0001; in_data = 16'h0008;
        for (int n = 0; n < 768; n++) step();
        check("wrap_cnt", toggle_cnt, 0); check("wrap_q", Q, 0);
        for (int n = 0; n < 2000; n++) begin
            Rst = ($urandom_range(63) == 0);
            req = NREQ'($urandom);
            in_data = 16'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
